// File: rtl/msk_rnd_pkg.sv
// Shared constants and the FSM state type for the masking PRNG.
package msk_rnd_pkg;
    localparam int          STATE_W       = 64;
    // Right-shift Galois taps for x^64+x^63+x^61+x^60+1 (bit e-1 per term x^e).
    localparam logic [63:0] LFSR_POLY     = 64'hD800_0000_0000_0000;
    localparam logic [63:0] ZERO_SEED_SUB = 64'h1;

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} fsm_e;
endpackage

// File: rtl/msk_rnd_prng_if.sv
// Seed input and randomness output handshakes of msk_rnd_prng.
interface msk_rnd_prng_if #(parameter int RND_W = 2);
    logic             seed_valid;
    logic             seed_ready;
    logic [63:0]      seed;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [RND_W-1:0] rnd;
    logic             reseed_req;

    modport master (output seed_valid, seed, rnd_ready,
                    input  seed_ready, rnd_valid, rnd, reseed_req);
    modport slave  (input  seed_valid, seed, rnd_ready,
                    output seed_ready, rnd_valid, rnd, reseed_req);
endinterface

// File: rtl/msk_lfsr_step.sv
// Combinational advance of the 64-bit Galois LFSR by N single-bit steps.
module msk_lfsr_step
    import msk_rnd_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [STATE_W-1:0] i_state,
    output logic [STATE_W-1:0] o_state
);
    always_comb begin
        logic [STATE_W-1:0] w_s;
        w_s = i_state;
        for (int i = 0; i < N; i++)
            w_s = {1'b0, w_s[STATE_W-1:1]} ^ (w_s[0] ? LFSR_POLY : '0);
        o_state = w_s;
    end
endmodule

// File: rtl/msk_rnd_prng.sv
// Seeded LFSR randomness source for masked gadgets, with warm-up after each seed.
// Optional delivered-word counter / reseed request: define MSK_RND_RESEED_REQ_EN.
module msk_rnd_prng
    import msk_rnd_pkg::*;
#(
    parameter int RND_W         = 2,
    parameter int WARMUP_CYCLES = 4,
    parameter int RESEED_PERIOD = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    msk_rnd_prng_if.slave bus
);
    localparam logic [7:0] WU_LAST = 8'(WARMUP_CYCLES);

    fsm_e               r_fsm, w_fsm_nxt;
    logic [STATE_W-1:0] r_state, w_state_adv, w_seed_ld;
    logic [7:0]         r_wcnt;
    logic [RND_W-1:0]   r_rnd;
    logic               r_vld;
    logic               w_seed_rdy, w_seed_acc, w_hs;
    logic               w_load, w_adv, w_pub;

    msk_lfsr_step #(.N(RND_W)) u_step (.i_state(r_state), .o_state(w_state_adv));

    assign w_seed_rdy = (r_fsm != WARMUP);
    assign w_seed_acc = bus.seed_valid & w_seed_rdy;
    assign w_hs       = (r_fsm == RUN) & r_vld & bus.rnd_ready;
    assign w_seed_ld  = (bus.seed == '0) ? ZERO_SEED_SUB : bus.seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    // A seed offered on a RUN handshake edge wins; the word still counts as consumed.
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_load    = 1'b0;
        w_adv     = 1'b0;
        w_pub     = 1'b0;
        case (r_fsm)
            IDLE: if (w_seed_acc) begin
                w_fsm_nxt = WARMUP;
                w_load    = 1'b1;
            end
            WARMUP: begin
                w_adv = 1'b1;
                if (r_wcnt == WU_LAST) begin
                    w_pub     = 1'b1;
                    w_fsm_nxt = RUN;
                end
            end
            RUN: if (w_seed_acc) begin
                w_fsm_nxt = WARMUP;
                w_load    = 1'b1;
            end else if (w_hs) begin
                w_adv = 1'b1;
                w_pub = 1'b1;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // WARMUP_CYCLES discarded advances, then the publishing advance on the last edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ZERO_SEED_SUB;
            r_rnd   <= '0;
            r_vld   <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            if (w_load) begin
                r_state <= w_seed_ld;
                r_vld   <= 1'b0;
                r_wcnt  <= '0;
            end else if (w_adv) begin
                r_state <= w_state_adv;
            end
            if (r_fsm == WARMUP) r_wcnt <= r_wcnt + 8'd1;
            if (w_pub) begin
                r_rnd <= w_state_adv[RND_W-1:0];
                r_vld <= 1'b1;
            end
        end
    end

    assign bus.seed_ready = w_seed_rdy;
    assign bus.rnd_valid  = r_vld;
    assign bus.rnd        = r_rnd;

`ifdef MSK_RND_RESEED_REQ_EN
    localparam int             CNT_W = $clog2(RESEED_PERIOD + 1);
    localparam logic [CNT_W-1:0] PER = CNT_W'(RESEED_PERIOD);

    logic [CNT_W-1:0] r_dcnt;
    logic             r_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt <= '0;
            r_req  <= 1'b0;
        end else if (w_load) begin
            r_dcnt <= '0;
            r_req  <= 1'b0;
        end else if (w_hs && (r_dcnt != PER)) begin
            r_dcnt <= r_dcnt + 1'b1;
            if (r_dcnt == PER - 1'b1) r_req <= 1'b1;
        end
    end

    assign bus.reseed_req = r_req;
`else
    // Always 0 for any legal RESEED_PERIOD; keeps the parameter referenced.
    assign bus.reseed_req = (RESEED_PERIOD < 0);
`endif
endmodule

// File: doc/msk_rnd_prng.md
MSK_RND_PRNG -- requirements
Module: msk_rnd_prng

Interface
REQ-001 Parameter RND_W, default 2, meaning number of fresh random bits delivered per handshake (legal range 1..64; matches gadget rnd width).
REQ-002 Parameter WARMUP_CYCLES, default 4, meaning number of discarded state advances after each seed load (legal range 1..255).
REQ-003 Parameter RESEED_PERIOD, default 1024, meaning number of delivered words before a reseed request (legal range 2..2^16).
REQ-004 clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 seed_valid  input  1  seed offered.
REQ-007 seed_ready  output  1  seed can be accepted this cycle.
REQ-008 seed  input  64  seed value.
REQ-009 rnd_valid  output  1  rnd holds an undelivered fresh word.
REQ-010 rnd_ready  input  1  downstream gadget pipeline consumes rnd this cycle.
REQ-011 rnd  output  RND_W  fresh randomness for masked gadgets.
REQ-012 reseed_req  output  1  reseed requested (see Configuration).

Function
REQ-013 Internal state SHALL be a 64-bit Galois LFSR, polynomial x^64+x^63+x^61+x^60+1, advanced exactly RND_W single-bit steps per advance.
REQ-014 FSM states SHALL be IDLE (unseeded), WARMUP, RUN.
REQ-015 seed_ready SHALL be 1 in IDLE and RUN, 0 in WARMUP; seed accepted on an edge where seed_valid and seed_ready are both 1.
REQ-016 An accepted seed of zero SHALL load 64'h1; any other seed loads unchanged.
REQ-017 On seed accept, FSM SHALL enter WARMUP, clear rnd_valid at that edge, and advance the state once per cycle for WARMUP_CYCLES cycles.
REQ-018 For a seed accepted at edge k, rnd_valid SHALL rise at edge k+WARMUP_CYCLES+1, with rnd = low RND_W bits of the state after WARMUP_CYCLES+1 advances; FSM enters RUN at that edge.
REQ-019 In RUN, rnd and rnd_valid SHALL stay unchanged while rnd_valid=1 and rnd_ready=0.
REQ-020 In RUN, on an edge with rnd_valid=1 and rnd_ready=1, the state SHALL advance once and rnd SHALL take the new low RND_W bits; rnd_valid stays 1 (one word per cycle at full throughput).
REQ-021 rnd_ready SHALL be ignored outside RUN.
REQ-022 Seed accept and rnd handshake on the same RUN edge: the current word counts as delivered; the seed wins, per REQ-017.
REQ-023 No value of rnd SHALL ever be presented with rnd_valid=1 twice across separate handshakes (no word reuse).

Reset
REQ-024 rst_n low SHALL asynchronously force FSM=IDLE, state=64'h1, rnd=0, rnd_valid=0, reseed_req=0, delivered-word counter=0; seed_ready=1 after release.
REQ-025 Reset asserted mid-WARMUP or mid-RUN SHALL discard the seed; no rnd_valid until a new seed is accepted.

Configuration
REQ-026 Macro MSK_RND_RESEED_REQ_EN defined: a delivered-word counter SHALL increment per rnd handshake, saturate at RESEED_PERIOD, assert reseed_req (registered) when it reaches RESEED_PERIOD, and clear counter and reseed_req on seed accept; output generation continues while reseed_req=1.
REQ-027 Macro not defined: no counter SHALL be built and reseed_req SHALL be tied to 0.

Structure
REQ-028 Package msk_rnd_pkg SHALL hold the LFSR polynomial constant, the 64-bit state width constant, the zero-seed substitute constant and the FSM state enum typedef.
REQ-029 Sub-module msk_lfsr_step (combinational, parameter N, 64-bit state in, 64-bit state out after N steps) SHALL implement the advance; msk_rnd_prng instantiates it once with N=RND_W.

Verification
REQ-030 Reset, seed=64'h0123_4567_89AB_CDEF at edge k, rnd_ready=1 -> rnd_valid rises at edge k+5 (WARMUP_CYCLES=4), rnd matches golden LFSR model every cycle for 1000 words.
REQ-031 seed=0 -> output sequence identical to seed=64'h1.
REQ-032 RUN, rnd_ready held 0 for 7 cycles -> rnd constant and rnd_valid=1 for those 7 cycles; next word after release is the model's next word.
REQ-033 Seed offered during WARMUP -> seed_ready=0, not accepted; same seed accepted in RUN concurrently with a rnd handshake -> rnd_valid drops next edge, restart per REQ-018.
REQ-034 rst_n pulsed low mid-RUN (between edges) -> rnd_valid=0 and rnd=0 immediately; no output until reseeded.
REQ-035 With MSK_RND_RESEED_REQ_EN, RESEED_PERIOD=4 -> reseed_req=1 after 4th handshake, stays 1 through further words, clears on seed accept; without macro reseed_req constant 0.
